// File: rtl/fns_pkg.sv
// Shared types and constant helpers for the FNS crosstalk-avoidance codeword decoder.
package fns_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } fns_dec_state_e;

  // FNS weight of bit i: 1, 2, 3, 5, 8, ...
  function automatic int unsigned fns_weight(input int unsigned i);
    int unsigned a;
    int unsigned b;
    int unsigned t;
    a = 1;
    b = 2;
    if (i == 0) return 1;
    for (int unsigned k = 1; k < i; k++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return b;
  endfunction

  // Width needed to hold any legal decoded value: clog2(W[code_w]).
  function automatic int unsigned fns_data_w(input int unsigned code_w);
    return $clog2(fns_weight(code_w));
  endfunction

endpackage

// File: rtl/fns_slice_sum.sv
// Combinational weighted sum of one BITS_PER_CYC-wide codeword slice.
// Slice k covers codeword bits k*BITS_PER_CYC and up; positions past CODE_W weigh zero.
module fns_slice_sum
  import fns_pkg::*;
#(
  parameter int unsigned CODE_W       = 11,
  parameter int unsigned BITS_PER_CYC = 1,
  parameter int unsigned SUM_W        = 9,
  parameter int unsigned IDX_W        = 4
) (
  input  logic [IDX_W-1:0]        slice_idx_i,
  input  logic [BITS_PER_CYC-1:0] bits_i,
  output logic [SUM_W-1:0]        sum_o
);

  localparam int unsigned NumSlices = (CODE_W + BITS_PER_CYC - 1) / BITS_PER_CYC;
  // One spare slice so the index stays in range while the counter sits at its final value.
  localparam int unsigned TabN      = (NumSlices + 1) * BITS_PER_CYC;
  localparam int unsigned TabIdxW   = $clog2(TabN);

  logic [SUM_W-1:0] wt_tab [TabN];

  for (genvar g = 0; g < TabN; g++) begin : g_wt
    if (g < CODE_W) begin : g_live
      assign wt_tab[g] = SUM_W'(fns_weight(g));
    end else begin : g_pad
      assign wt_tab[g] = '0;
    end
  end

  logic [TabIdxW-1:0] base;

  // Add the table weight of every set bit in the slice.
  always_comb begin
    logic [TabIdxW-1:0] idx;
    sum_o = '0;
    base  = TabIdxW'(slice_idx_i) * TabIdxW'(BITS_PER_CYC);
    for (int j = 0; j < int'(BITS_PER_CYC); j++) begin
      idx = base + TabIdxW'(j);
      if (bits_i[j]) sum_o = sum_o + wt_tab[idx];
    end
  end

endmodule

// File: rtl/fns_cac_dec_seq.sv
// Multi-cycle FNS codeword decoder with valid/ready on both sides.
// Optional macro FNS_DEC_LEGAL_CHECK_EN adds an adjacent-ones detector driving out_err.
module fns_cac_dec_seq
  import fns_pkg::*;
#(
  parameter int unsigned CODE_W       = 11,
  parameter int unsigned BITS_PER_CYC = 1,
  parameter int unsigned DATA_W       = fns_data_w(CODE_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CODE_W-1:0] codein,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] dataout,
  output logic              out_err
);

  localparam int unsigned NumSlices = (CODE_W + BITS_PER_CYC - 1) / BITS_PER_CYC;
  localparam int unsigned CntW      = $clog2(NumSlices + 1);
  localparam int unsigned AccW      = DATA_W + 1;

  fns_dec_state_e    state_q, state_d;
  logic [CODE_W-1:0] shift_q, shift_d;
  logic [AccW-1:0]   acc_q, acc_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0] dout_q, dout_d;

  logic [BITS_PER_CYC-1:0] slice;
  logic [AccW-1:0]         slice_sum;
  logic                    accept;
  logic                    run_step;

  assign slice    = shift_q[BITS_PER_CYC-1:0];
  assign accept   = (state_q == StIdle) && in_valid;
  // The counter reaching NumSlices marks the extra cycle that publishes the result.
  assign run_step = (state_q == StRun) && (cnt_q != CntW'(NumSlices));

  fns_slice_sum #(
    .CODE_W      (CODE_W),
    .BITS_PER_CYC(BITS_PER_CYC),
    .SUM_W       (AccW),
    .IDX_W       (CntW)
  ) u_slice_sum (
    .slice_idx_i(cnt_q),
    .bits_i     (slice),
    .sum_o      (slice_sum)
  );

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      shift_q <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          shift_d = codein;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        if (run_step) begin
          acc_d   = acc_q + slice_sum;
          shift_d = shift_q >> BITS_PER_CYC;
          cnt_d   = cnt_q + 1'b1;
        end else begin
          dout_d  = acc_q[DATA_W-1:0];
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign dataout   = dout_q;

`ifdef FNS_DEC_LEGAL_CHECK_EN
  logic err_q, err_d;
  logic msb_q, msb_d;

  // Error and carried-MSB registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
      msb_q <= 1'b0;
    end else begin
      err_q <= err_d;
      msb_q <= msb_d;
    end
  end

  // Flag adjacent ones inside a slice and across the boundary with the previous slice.
  always_comb begin
    err_d = err_q;
    msb_d = msb_q;
    if (accept) begin
      err_d = 1'b0;
      msb_d = 1'b0;
    end else if (run_step) begin
      err_d = err_q | (|(slice & (slice >> 1))) | (msb_q & slice[0]);
      msb_d = slice[BITS_PER_CYC-1];
    end
  end

  assign out_err = err_q;
`else
  assign out_err = 1'b0;
`endif

endmodule

// File: tb/tb_fns_cac_dec_seq.sv
// Directed bench for fns_cac_dec_seq: one instance with 1 bit/cycle, one with 4 bits/cycle.
module tb_fns_cac_dec_seq;

`ifdef FNS_DEC_LEGAL_CHECK_EN
  localparam logic ChkEn = 1'b1;
`else
  localparam logic ChkEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  in_valid = '0;
  logic [1:0]  in_ready;
  logic [10:0] codein [2];
  logic [1:0]  out_valid;
  logic [1:0]  out_ready = '0;
  logic [7:0]  dataout [2];
  logic [1:0]  out_err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fns_cac_dec_seq #(.CODE_W(11), .BITS_PER_CYC(1)) u_dut1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid[0]),
    .in_ready (in_ready[0]),
    .codein   (codein[0]),
    .out_valid(out_valid[0]),
    .out_ready(out_ready[0]),
    .dataout  (dataout[0]),
    .out_err  (out_err[0])
  );

  fns_cac_dec_seq #(.CODE_W(11), .BITS_PER_CYC(4)) u_dut4 (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid[1]),
    .in_ready (in_ready[1]),
    .codein   (codein[1]),
    .out_valid(out_valid[1]),
    .out_ready(out_ready[1]),
    .dataout  (dataout[1]),
    .out_err  (out_err[1])
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  function automatic int ref_decode(input logic [10:0] cw);
    int w [11];
    int s;
    w[0] = 1;
    w[1] = 2;
    for (int i = 2; i < 11; i++) w[i] = w[i-1] + w[i-2];
    s = 0;
    for (int i = 0; i < 11; i++) if (cw[i]) s += w[i];
    return s;
  endfunction

  // Offer one codeword, measure edges to out_valid, check result, then hand it off.
  task automatic run_word(input int d, input logic [10:0] cw, input int exp_v, input logic exp_e,
                          input int exp_lat, input string tag);
    int lat;
    @(negedge clk);
    check_eq({tag, "_in_ready"}, 32'(in_ready[d]), 32'd1);
    in_valid[d] = 1'b1;
    codein[d]   = cw;
    @(posedge clk);
    #1;
    in_valid[d] = 1'b0;
    lat = 0;
    while (!out_valid[d] && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check_eq({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check_eq({tag, "_data"}, 32'(dataout[d]), 32'(exp_v));
    check_eq({tag, "_err"}, 32'(out_err[d]), 32'(exp_e));
    @(negedge clk);
    out_ready[d] = 1'b1;
    @(posedge clk);
    #1;
    out_ready[d] = 1'b0;
    check_eq({tag, "_valid_drop"}, 32'(out_valid[d]), 32'd0);
  endtask

  initial begin
    int lat;
    int sent;
    int rcvd;
    int cyc;
    int exp_q [$];
    logic [10:0] cw;
    logic have_word;

    codein[0] = '0;
    codein[1] = '0;
    #12;
    check_eq("rst_in_ready", 32'(in_ready[0]), 32'd1);
    check_eq("rst_out_valid", 32'(out_valid[0]), 32'd0);
    check_eq("rst_dataout", 32'(dataout[0]), 32'd0);
    check_eq("rst_out_err", 32'(out_err[0]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic decodes, one bit per cycle: latency L+1 = 12.
    run_word(0, 11'h001, 1, 1'b0, 12, "b1_001");
    run_word(0, 11'h400, 144, 1'b0, 12, "b1_400");
    run_word(0, 11'h555, 232, 1'b0, 12, "b1_555");
    run_word(0, 11'h000, 0, 1'b0, 12, "b1_zero");
    run_word(0, 11'h555, 232, 1'b0, 12, "b1_555b");

    // Four bits per cycle: L=3, latency 4.
    run_word(1, 11'h2AA, 143, 1'b0, 4, "b4_2aa");
    run_word(1, 11'h555, 232, 1'b0, 4, "b4_555");

    // Backpressure in DONE; a stray in_valid must be ignored.
    @(negedge clk);
    in_valid[1] = 1'b1;
    codein[1]   = 11'h155;
    @(posedge clk);
    #1;
    in_valid[1] = 1'b0;
    lat = 0;
    while (!out_valid[1] && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check_eq("bp_latency", 32'(lat), 32'd4);
    codein[1]   = 11'h001;
    in_valid[1] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_eq("bp_valid", 32'(out_valid[1]), 32'd1);
      check_eq("bp_data", 32'(dataout[1]), 32'd88);
      check_eq("bp_err", 32'(out_err[1]), 32'd0);
      check_eq("bp_in_ready", 32'(in_ready[1]), 32'd0);
    end
    in_valid[1]  = 1'b0;
    out_ready[1] = 1'b1;
    @(posedge clk);
    #1;
    out_ready[1] = 1'b0;
    check_eq("bp_released", 32'(out_valid[1]), 32'd0);

    // Async reset mid-RUN discards the partial sum and clears the held output.
    @(negedge clk);
    in_valid[0] = 1'b1;
    codein[0]   = 11'h400;
    @(posedge clk);
    #1;
    in_valid[0] = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("rstrun_valid", 32'(out_valid[0]), 32'd0);
    check_eq("rstrun_data", 32'(dataout[0]), 32'd0);
    check_eq("rstrun_err", 32'(out_err[0]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_word(0, 11'h155, 88, 1'b0, 12, "rstrun_next");

    // Illegal words: raw sum still reported, out_err only with the detector built in.
    run_word(0, 11'h003, 3, ChkEn, 12, "b1_adj003");
    run_word(1, 11'h003, 3, ChkEn, 4, "b4_adj003");
    run_word(1, 11'h018, 13, ChkEn, 4, "b4_adj018");
    run_word(1, 11'h2AA, 143, 1'b0, 4, "b4_err_clear");

    // Random legal words with random valid/ready duty on the 4-bit instance.
    sent = 0;
    rcvd = 0;
    cyc = 0;
    have_word = 1'b0;
    cw = '0;
    while ((sent < 30 || rcvd < 30) && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      out_ready[1] = 1'($urandom_range(0, 1));
      if (out_valid[1] && out_ready[1]) begin
        if (exp_q.size() == 0) begin
          check_eq("rnd_dup", 32'd1, 32'd0);
        end else begin
          check_eq("rnd_data", 32'(dataout[1]), 32'(exp_q.pop_front()));
          check_eq("rnd_err", 32'(out_err[1]), 32'd0);
        end
        rcvd++;
      end
      if (!have_word && sent < 30) begin
        cw = '0;
        for (int i = 0; i < 11; i++) begin
          if ((i == 0 || !cw[i-1]) && $urandom_range(0, 1) == 1) cw[i] = 1'b1;
        end
        have_word = 1'b1;
      end
      codein[1]   = cw;
      in_valid[1] = have_word && ($urandom_range(0, 2) != 0);
      if (in_valid[1] && in_ready[1]) begin
        exp_q.push_back(ref_decode(cw));
        sent++;
        have_word = 1'b0;
      end
    end
    @(negedge clk);
    in_valid[1]  = 1'b0;
    out_ready[1] = 1'b0;
    check_eq("rnd_sent", 32'(sent), 32'd30);
    check_eq("rnd_rcvd", 32'(rcvd), 32'd30);
    check_eq("rnd_left", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
